// File: rtl/operand_fetch.sv
// operand_fetch
//   Two-operand fetch sequencer in front of a single-read-port register bank.
//   A request (rs/rt) is accepted in IDLE. Both reads go out through the one
//   bank read port, rs first, then rt. Each operand is the register value as
//   of the cycle its address was presented, including a write-back landing in
//   that same cycle. Both operands are then offered to execute with a
//   valid/ready handshake.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   req_valid/ready    decode handshake; rs_addr/rt_addr sampled on accept
//   wb_we/addr/data    write-back bus, observed only (mirrors bank write port)
//   rf_read_addr       bank read address
//   rf_q               bank registered read data (one cycle after address)
//   op_valid/ready     execute handshake
//   op_a, op_b         fetched values of rs and rt
module operand_fetch #(
   parameter int DATA_WIDTH = 31,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_R0    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] rs_addr,
   input  logic [ADDR_WIDTH-1:0] rt_addr,
   input  logic                  wb_we,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic [ADDR_WIDTH-1:0] rf_read_addr,
   input  logic [DATA_WIDTH-1:0] rf_q,
   output logic                  op_valid,
   input  logic                  op_ready,
   output logic [DATA_WIDTH-1:0] op_a,
   output logic [DATA_WIDTH-1:0] op_b
);

   typedef enum logic [1:0] {IDLE, RD_A, RD_B, DONE} state_t;

   localparam logic ZERO_EN = (ZERO_R0 != 0);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rt_q, rt_d;
   // One bypass/zero flag set is enough: A's flags are consumed in RD_A on
   // the same edge that B's flags are loaded.
   logic                  byp_q, byp_d;
   logic                  zero_q, zero_d;
   logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
   logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
   logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
   logic                  op_valid_q, op_valid_d;
   logic [DATA_WIDTH-1:0] sel_val;

   // Bank data is the pre-write content; a write in the address cycle wins.
   assign sel_val = zero_q ? '0 : (byp_q ? byp_data_q : rf_q);

   always_comb begin
      state_d    = state_q;
      rt_d       = rt_q;
      byp_d      = byp_q;
      zero_d     = zero_q;
      byp_data_d = byp_data_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      op_valid_d = op_valid_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               rt_d       = rt_addr;
               byp_d      = wb_we && (wb_addr == rs_addr);
               byp_data_d = wb_data;
               zero_d     = ZERO_EN && (rs_addr == '0);
               state_d    = RD_A;
            end
         end
         RD_A: begin
            op_a_d     = sel_val;
            byp_d      = wb_we && (wb_addr == rt_q);
            byp_data_d = wb_data;
            zero_d     = ZERO_EN && (rt_q == '0);
            state_d    = RD_B;
         end
         RD_B: begin
            op_b_d     = sel_val;
            op_valid_d = 1'b1;
            state_d    = DONE;
         end
         DONE: begin
            if (op_ready) begin
               op_valid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rt_q       <= '0;
         byp_q      <= 1'b0;
         zero_q     <= 1'b0;
         byp_data_q <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rt_q       <= rt_d;
         byp_q      <= byp_d;
         zero_q     <= zero_d;
         byp_data_q <= byp_data_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         op_valid_q <= op_valid_d;
      end
   end

   // rs goes straight to the bank in IDLE so its read lands in RD_A.
   assign rf_read_addr = (state_q == IDLE) ? rs_addr : rt_q;
   assign req_ready    = rst_n && (state_q == IDLE);
   assign op_valid     = op_valid_q;
   assign op_a         = op_a_q;
   assign op_b         = op_b_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a ZERO_R0=1 and a ZERO_R0=0 instance share the
// stimulus, each with its own registered read port on a common bank model.
module tb_operand_fetch;
   localparam int DW = 31;
   localparam int AW = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, req_valid, op_ready, wb_we;
   logic [AW-1:0] rs_addr, rt_addr, wb_addr;
   logic [DW-1:0] wb_data;
   logic          req_ready, op_valid, req_ready0, op_valid0;
   logic [AW-1:0] rf_read_addr, rf_read_addr0;
   logic [DW-1:0] rf_q, rf_q0, op_a, op_b, op_a0, op_b0;

   operand_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_R0(1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .wb_we(wb_we), .wb_addr(wb_addr),
      .wb_data(wb_data), .rf_read_addr(rf_read_addr), .rf_q(rf_q),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b));

   operand_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_R0(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready0),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .wb_we(wb_we), .wb_addr(wb_addr),
      .wb_data(wb_data), .rf_read_addr(rf_read_addr0), .rf_q(rf_q0),
      .op_valid(op_valid0), .op_ready(op_ready), .op_a(op_a0), .op_b(op_b0));

   // Register bank: registered read of the pre-write content.
   logic [DW-1:0] mem [32];
   always @(posedge clk) begin
      if (wb_we) mem[wb_addr] <= wb_data;
      rf_q  <= mem[rf_read_addr];
      rf_q0 <= mem[rf_read_addr0];
   end

   // Architectural register file as the bench sees it.
   logic [DW-1:0] ref_regs [32];
   int checks = 0;
   int failures = 0;
   logic [DW-1:0] last_a, last_b, last_a0, last_b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      we = wb_we; a = wb_addr; d = wb_data;
      @(posedge clk);
      if (we) ref_regs[a] = d;
      #1;
   endtask

   // Register value as of this cycle, counting a write in this same cycle.
   function automatic logic [DW-1:0] snap(input logic [AW-1:0] a, input logic we,
                                          input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                          input bit zr);
      if (zr && a == '0) return '0;
      if (we && wa == a) return wd;
      return ref_regs[a];
   endfunction

   task automatic rand_wb(input logic [AW-1:0] x, input logic [AW-1:0] y);
      wb_we   = 1'($urandom);
      wb_addr = ($urandom_range(0, 1) == 1) ? x : y;
      wb_data = DW'($urandom);
   endtask

   task automatic run_req(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic we0, input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                          input logic we1, input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
                          input int stall);
      logic [DW-1:0] ea, eb, ea0, eb0;
      // accept cycle
      req_valid = 1'b1; rs_addr = rs; rt_addr = rt;
      wb_we = we0; wb_addr = wa0; wb_data = wd0; op_ready = 1'($urandom);
      #1;
      chk("idle_req_ready", 32'(req_ready), 32'd1);
      chk("idle_raddr", 32'(rf_read_addr), 32'(rs));
      ea  = snap(rs, we0, wa0, wd0, 1'b1);
      ea0 = snap(rs, we0, wa0, wd0, 1'b0);
      tick();
      // rt address cycle; a stray request must be ignored
      req_valid = 1'($urandom); rs_addr = AW'($urandom); rt_addr = AW'($urandom);
      wb_we = we1; wb_addr = wa1; wb_data = wd1;
      #1;
      chk("rda_req_ready", 32'(req_ready), 32'd0);
      chk("rda_raddr", 32'(rf_read_addr), 32'(rt));
      chk("rda_op_valid", 32'(op_valid), 32'd0);
      eb  = snap(rt, we1, wa1, wd1, 1'b1);
      eb0 = snap(rt, we1, wa1, wd1, 1'b0);
      tick();
      // later writes must not leak into captured operands
      rand_wb(rs, rt); req_valid = 1'($urandom);
      #1;
      chk("rdb_raddr", 32'(rf_read_addr), 32'(rt));
      chk("rdb_op_valid", 32'(op_valid), 32'd0);
      tick();
      for (int i = 0; i <= stall; i++) begin
         op_ready = (i == stall); req_valid = 1'($urandom);
         rs_addr = AW'($urandom); rand_wb(rs, rt);
         #1;
         chk("done_op_valid", 32'(op_valid), 32'd1);
         chk("done_op_valid0", 32'(op_valid0), 32'd1);
         chk("done_req_ready", 32'(req_ready), 32'd0);
         chk("op_a", 32'(op_a), 32'(ea));
         chk("op_b", 32'(op_b), 32'(eb));
         chk("op_a_nz", 32'(op_a0), 32'(ea0));
         chk("op_b_nz", 32'(op_b0), 32'(eb0));
         last_a = op_a; last_b = op_b; last_a0 = op_a0; last_b0 = op_b0;
         tick();
      end
      req_valid = 1'b0; wb_we = 1'b0; op_ready = 1'b0;
      #1;
      chk("post_op_valid", 32'(op_valid), 32'd0);
      chk("post_req_ready", 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [AW-1:0] rs, rt, wa0, wa1;
      rst_n = 1'b0; req_valid = 1'b0; op_ready = 1'b0; wb_we = 1'b0;
      rs_addr = '0; rt_addr = '0; wb_addr = '0; wb_data = '0;
      for (int i = 0; i < 32; i++) ref_regs[i] = '0;
      #1;
      tick(); tick();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_req_ready0", 32'(req_ready0), 32'd0);
      chk("rst_op_valid", 32'(op_valid), 32'd0);
      chk("rst_op_a", 32'(op_a), 32'd0);
      chk("rst_op_b", 32'(op_b), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_rel_req_ready", 32'(req_ready), 32'd1);

      // preload through the write port
      for (int i = 0; i < 32; i++) begin
         wb_we = 1'b1; wb_addr = AW'(i); wb_data = DW'($urandom);
         tick();
      end
      wb_addr = 5'd3; wb_data = 31'h1234; tick();
      wb_addr = 5'd7; wb_data = 31'h5A5A; tick();
      wb_addr = 5'd4; wb_data = 31'h1;    tick();
      wb_addr = 5'd9; wb_data = 31'h10;   tick();
      wb_we = 1'b0;
      #1;

      // no hazard
      run_req(5'd3, 5'd7, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 0);
      chk("nohaz_a", 32'(last_a), 32'h1234);
      chk("nohaz_b", 32'(last_b), 32'h5A5A);

      // same-cycle bypass on A, later write ignored
      run_req(5'd4, 5'd5, 1'b1, 5'd4, 31'h0ABC, 1'b1, 5'd4, 31'h2222, 0);
      chk("bypA_a", 32'(last_a), 32'h0ABC);

      // rs==rt with a write between the two reads
      run_req(5'd9, 5'd9, 1'b0, 5'd0, '0, 1'b1, 5'd9, 31'h20, 0);
      chk("bypB_a", 32'(last_a), 32'h10);
      chk("bypB_b", 32'(last_b), 32'h20);

      // zero register
      run_req(5'd0, 5'd0, 1'b1, 5'd0, 31'h7FFF_FFFF, 1'b0, 5'd0, '0, 0);
      chk("zero_a", 32'(last_a), 32'd0);
      chk("zero_b", 32'(last_b), 32'd0);
      chk("nozero_a", 32'(last_a0), 32'h7FFF_FFFF);

      // backpressure
      run_req(5'd11, 5'd12, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5);

      // reset while in RD_B
      req_valid = 1'b1; rs_addr = 5'd3; rt_addr = 5'd7; wb_we = 1'b0;
      #1;
      tick();
      req_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req_ready_a", 32'(req_ready), 32'd0);
      tick();
      chk("mid_rst_op_valid", 32'(op_valid), 32'd0);
      chk("mid_rst_op_a", 32'(op_a), 32'd0);
      chk("mid_rst_op_b", 32'(op_b), 32'd0);
      chk("mid_rst_req_ready_b", 32'(req_ready), 32'd0);
      chk("mid_rst_idle_raddr", 32'(rf_read_addr), 32'(rs_addr));
      tick();
      rst_n = 1'b1;
      #1;
      chk("mid_rst_rel_req_ready", 32'(req_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("mid_rst_no_stale", 32'(op_valid), 32'd0);
      end

      // randomized traffic with hazards biased in
      for (int n = 0; n < 24; n++) begin
         rs  = ($urandom_range(0, 3) == 0) ? 5'd0 : AW'($urandom);
         rt  = ($urandom_range(0, 3) == 0) ? rs : AW'($urandom);
         wa0 = ($urandom_range(0, 1) == 1) ? rs : AW'($urandom);
         wa1 = ($urandom_range(0, 1) == 1) ? rt : AW'($urandom);
         run_req(rs, rt, 1'($urandom), wa0, DW'($urandom),
                 1'($urandom), wa1, DW'($urandom), int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
